// File: rtl/systolic_mmu_stream.sv
// systolic_mmu_stream: weight-stationary ROWS x COLS systolic matrix-multiply
// engine. Activations enter aligned, are skewed per row, flow right through
// the PEs while partial sums flow down, and are deskewed per column so one
// aligned vector in yields one aligned result vector out ROWS+COLS enabled
// edges later. Weights are double-buffered: a shadow matrix is loaded row by
// row over a ready/valid port, and a swap flag travelling with the data
// wavefront copies shadow to active in each PE exactly when that vector
// reaches it.
module systolic_mmu_stream #(
  parameter int DATA_WIDTH             = 8,
  parameter int ACCUMULATOR_DATA_WIDTH = 32,
  parameter int ROWS                   = 4,
  parameter int COLS                   = 4
) (
  input  logic                                     CLK,
  input  logic                                     ASYNC_RST,
  input  logic                                     SYNC_RST,
  input  logic                                     EN,
  input  logic                                     IN_VALID,
  input  logic                                     SWAP,
  input  logic signed [DATA_WIDTH-1:0]             Inputs [ROWS],
  input  logic                                     W_VALID,
  output logic                                     W_READY,
  input  logic signed [DATA_WIDTH-1:0]             W_Data [COLS],
  output logic                                     W_FULL,
  output logic                                     SWAP_ERR,
  output logic                                     OUT_VALID,
  output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] Result [COLS]
);

  localparam int DW  = DATA_WIDTH;
  localparam int AW  = ACCUMULATOR_DATA_WIDTH;
  localparam int LAT = ROWS + COLS;
  localparam int BCW = $clog2(ROWS + 1);
  localparam int SCW = $clog2(ROWS + COLS);

  logic [BCW-1:0] beat_cnt;
  logic [SCW-1:0] busy_cnt;
  logic [LAT-1:0] vld_q;
  logic           w_load;
  logic           swap_req;
  logic           swap_go;

  logic signed [DW-1:0] a_h     [ROWS][COLS];
  logic                 s_h     [ROWS][COLS];
  logic signed [AW-1:0] p_v     [ROWS+1][COLS];
  logic signed [AW-1:0] col_out [COLS];

  assign w_load   = W_VALID & W_READY;
  assign swap_req = EN & IN_VALID & SWAP;
  assign swap_go  = swap_req & W_FULL;
  // Shadow is writable only when not full and no swap is still propagating.
  assign W_READY  = ~W_FULL & (busy_cnt == '0);

  // Shadow beat counter and full flag; runs regardless of EN.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      beat_cnt <= '0;
      W_FULL   <= 1'b0;
    end else if (SYNC_RST) begin
      beat_cnt <= '0;
      W_FULL   <= 1'b0;
    end else if (swap_go) begin
      beat_cnt <= '0;
      W_FULL   <= 1'b0;
    end else if (w_load) begin
      if (beat_cnt == BCW'(ROWS - 1)) W_FULL <= 1'b1;
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Busy window: counts enabled edges until the last PE has taken the swap.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      busy_cnt <= '0;
    end else if (SYNC_RST) begin
      busy_cnt <= '0;
    end else if (swap_go) begin
      busy_cnt <= SCW'(ROWS + COLS - 1);
    end else if (EN && (busy_cnt != '0)) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

  // Swap requested without a complete shadow matrix.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST)    SWAP_ERR <= 1'b0;
    else if (SYNC_RST) SWAP_ERR <= 1'b0;
    else               SWAP_ERR <= swap_req & ~W_FULL;
  end

  // Valid bits shadow the data path depth so bubbles stay in place.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST)    vld_q <= '0;
    else if (SYNC_RST) vld_q <= '0;
    else if (EN)       vld_q <= {vld_q[LAT-2:0], IN_VALID};
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    // Stage 0 is the input capture; row r adds r more delay stages.
    logic signed [DW-1:0] sk_a [r+1];
    logic                 sk_s [r+1];

    // Input capture and per-row skew of activation and swap flag.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
        for (int k = 0; k <= r; k++) begin
          sk_a[k] <= '0;
          sk_s[k] <= 1'b0;
        end
      end else if (SYNC_RST) begin
        for (int k = 0; k <= r; k++) begin
          sk_a[k] <= '0;
          sk_s[k] <= 1'b0;
        end
      end else if (EN) begin
        sk_a[0] <= IN_VALID ? Inputs[r] : '0;
        sk_s[0] <= swap_go;
        for (int k = 1; k <= r; k++) begin
          sk_a[k] <= sk_a[k-1];
          sk_s[k] <= sk_s[k-1];
        end
      end
    end

    assign a_h[r][0] = sk_a[r];
    assign s_h[r][0] = sk_s[r];

    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [DW-1:0]   w_act;
      logic signed [DW-1:0]   w_sh;
      logic signed [DW-1:0]   w_use;
      logic signed [2*DW-1:0] prod;
      logic signed [AW-1:0]   p_q;

      // A flagged activation multiplies with the incoming weight directly.
      assign w_use = s_h[r][c] ? w_sh : w_act;
      assign prod  = a_h[r][c] * w_use;

      // Shadow weight: filled by the beat whose index matches this row.
      always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST)    w_sh <= '0;
        else if (SYNC_RST) w_sh <= '0;
        else if (w_load && (beat_cnt == BCW'(r))) w_sh <= W_Data[c];
      end

      // MAC stage; active weight is replaced as the swap wavefront passes.
      always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
          w_act <= '0;
          p_q   <= '0;
        end else if (SYNC_RST) begin
          w_act <= '0;
          p_q   <= '0;
        end else if (EN) begin
          p_q <= p_v[r][c] + AW'(prod);
          if (s_h[r][c]) w_act <= w_sh;
        end
      end

      assign p_v[r+1][c] = p_q;

      if (c < COLS - 1) begin : g_fwd
        logic signed [DW-1:0] a_q;
        logic                 s_q;

        // Forward activation and swap flag to the right-hand neighbour.
        always_ff @(posedge CLK or negedge ASYNC_RST) begin
          if (!ASYNC_RST) begin
            a_q <= '0;
            s_q <= 1'b0;
          end else if (SYNC_RST) begin
            a_q <= '0;
            s_q <= 1'b0;
          end else if (EN) begin
            a_q <= a_h[r][c];
            s_q <= s_h[r][c];
          end
        end

        assign a_h[r][c+1] = a_q;
        assign s_h[r][c+1] = s_q;
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign p_v[0][c] = '0;

    if (c == COLS - 1) begin : g_pass
      assign col_out[c] = p_v[ROWS][c];
    end else begin : g_dsk
      localparam int D = COLS - 1 - c;
      logic signed [AW-1:0] ds [D];

      // Column deskew: earlier columns wait for the last one.
      always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
          for (int k = 0; k < D; k++) ds[k] <= '0;
        end else if (SYNC_RST) begin
          for (int k = 0; k < D; k++) ds[k] <= '0;
        end else if (EN) begin
          ds[0] <= p_v[ROWS][c];
          for (int k = 1; k < D; k++) ds[k] <= ds[k-1];
        end
      end

      assign col_out[c] = ds[D-1];
    end
  end

  // Output register: Result holds across stalls, OUT_VALID never repeats.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      OUT_VALID <= 1'b0;
      for (int c = 0; c < COLS; c++) Result[c] <= '0;
    end else if (SYNC_RST) begin
      OUT_VALID <= 1'b0;
      for (int c = 0; c < COLS; c++) Result[c] <= '0;
    end else begin
      OUT_VALID <= EN & vld_q[LAT-1];
      if (EN && vld_q[LAT-1]) begin
        for (int c = 0; c < COLS; c++) Result[c] <= col_out[c];
      end
    end
  end

endmodule

// File: tb/tb_systolic_mmu_stream.sv
// Directed bench for systolic_mmu_stream with a 3x2 array and a 16-bit
// accumulator, so the wrap case and the small-matrix cases share one DUT.
module tb_systolic_mmu_stream;

  logic              CLK = 1'b0;
  logic              ASYNC_RST;
  logic              SYNC_RST;
  logic              EN;
  logic              IN_VALID;
  logic              SWAP;
  logic signed [7:0] Inputs [3];
  logic              W_VALID;
  logic              W_READY;
  logic signed [7:0] W_Data [2];
  logic              W_FULL;
  logic              SWAP_ERR;
  logic              OUT_VALID;
  logic signed [15:0] Result [2];

  int checks = 0;
  int errors = 0;

  systolic_mmu_stream #(
    .DATA_WIDTH(8),
    .ACCUMULATOR_DATA_WIDTH(16),
    .ROWS(3),
    .COLS(2)
  ) dut (
    .CLK(CLK),
    .ASYNC_RST(ASYNC_RST),
    .SYNC_RST(SYNC_RST),
    .EN(EN),
    .IN_VALID(IN_VALID),
    .SWAP(SWAP),
    .Inputs(Inputs),
    .W_VALID(W_VALID),
    .W_READY(W_READY),
    .W_Data(W_Data),
    .W_FULL(W_FULL),
    .SWAP_ERR(SWAP_ERR),
    .OUT_VALID(OUT_VALID),
    .Result(Result)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one cycle of stimulus, then check OUT_VALID and, when valid, Result.
  task automatic cyc(input string tag, input logic en, input logic iv, input logic sw,
                     input int a0, input int a1, input int a2,
                     input logic ov, input int e0, input int e1);
    EN        = en;
    IN_VALID  = iv;
    SWAP      = sw;
    Inputs[0] = 8'(a0);
    Inputs[1] = 8'(a1);
    Inputs[2] = 8'(a2);
    tick();
    chk({tag, ".ov"}, OUT_VALID, ov);
    if (ov) begin
      chk({tag, ".r0"}, Result[0], e0);
      chk({tag, ".r1"}, Result[1], e1);
    end
  endtask

  task automatic idle(input string tag, input logic ov, input int e0, input int e1);
    cyc(tag, 1'b1, 1'b0, 1'b0, 0, 0, 0, ov, e0, e1);
  endtask

  task automatic beat(input int w0, input int w1);
    EN        = 1'b1;
    IN_VALID  = 1'b0;
    SWAP      = 1'b0;
    W_VALID   = 1'b1;
    W_Data[0] = 8'(w0);
    W_Data[1] = 8'(w1);
    tick();
    W_VALID   = 1'b0;
  endtask

  initial begin
    ASYNC_RST = 1'b0;
    SYNC_RST  = 1'b0;
    EN        = 1'b0;
    IN_VALID  = 1'b0;
    SWAP      = 1'b0;
    W_VALID   = 1'b0;
    for (int i = 0; i < 3; i++) Inputs[i] = '0;
    for (int i = 0; i < 2; i++) W_Data[i] = '0;

    // Reset state
    tick();
    tick();
    chk("rst.ov", OUT_VALID, 1'b0);
    chk("rst.rdy", W_READY, 1'b1);
    chk("rst.full", W_FULL, 1'b0);
    chk("rst.err", SWAP_ERR, 1'b0);
    chk("rst.res0", Result[0], 0);
    chk("rst.res1", Result[1], 0);
    ASYNC_RST = 1'b1;
    tick();

    // Load W = [1,2],[3,4],[5,6]; a fourth beat while full must be dropped
    chk("ld.rdy", W_READY, 1'b1);
    beat(1, 2);
    beat(3, 4);
    chk("ld.partial", W_FULL, 1'b0);
    beat(5, 6);
    chk("ld.full", W_FULL, 1'b1);
    chk("ld.rdy_full", W_READY, 1'b0);
    beat(9, 9);
    chk("ld.drop_full", W_FULL, 1'b1);

    // Basic multiply with swap on the first vector
    cyc("b0", 1, 1, 1, 1, 1, 1, 0, 0, 0);
    chk("b0.full", W_FULL, 1'b0);
    chk("b0.rdy", W_READY, 1'b0);
    chk("b0.err", SWAP_ERR, 1'b0);
    cyc("b1", 1, 1, 0, 1, -1, 2, 0, 0, 0);
    chk("b1.rdy", W_READY, 1'b0);
    idle("b2", 0, 0, 0);
    chk("b2.rdy", W_READY, 1'b0);
    idle("b3", 0, 0, 0);
    chk("b3.rdy", W_READY, 1'b0);
    idle("b4", 0, 0, 0);
    chk("b4.rdy", W_READY, 1'b1);
    idle("b5", 1, 9, 12);
    idle("b6", 1, 8, 10);
    idle("b7", 0, 0, 0);

    // Streaming with one bubble
    cyc("s0", 1, 1, 0, 1, 0, 0, 0, 0, 0);
    cyc("s1", 1, 1, 0, 0, 1, 0, 0, 0, 0);
    idle("s2", 0, 0, 0);
    cyc("s3", 1, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc("s4", 1, 1, 0, 2, -1, 1, 0, 0, 0);
    idle("s5", 1, 1, 2);
    idle("s6", 1, 3, 4);
    idle("s7", 0, 0, 0);
    idle("s8", 1, 5, 6);
    idle("s9", 1, 4, 6);
    idle("s10", 0, 0, 0);

    // Swap mid-stream to an all-ones matrix
    beat(1, 1);
    beat(1, 1);
    beat(1, 1);
    chk("m.full", W_FULL, 1'b1);
    cyc("m0", 1, 1, 0, 1, 1, 1, 0, 0, 0);
    cyc("m1", 1, 1, 1, 1, 1, 1, 0, 0, 0);
    chk("m1.full", W_FULL, 1'b0);
    chk("m1.rdy", W_READY, 1'b0);
    idle("m2", 0, 0, 0);
    chk("m2.rdy", W_READY, 1'b0);
    idle("m3", 0, 0, 0);
    chk("m3.rdy", W_READY, 1'b0);
    idle("m4", 0, 0, 0);
    chk("m4.rdy", W_READY, 1'b0);
    idle("m5", 1, 9, 12);
    chk("m5.rdy", W_READY, 1'b1);
    idle("m6", 1, 3, 3);
    idle("m7", 0, 0, 0);

    // Swap with only two of three beats loaded
    beat(2, 2);
    beat(2, 2);
    chk("e.full", W_FULL, 1'b0);
    cyc("e0", 1, 1, 1, 1, 2, 3, 0, 0, 0);
    chk("e0.err", SWAP_ERR, 1'b1);
    chk("e0.rdy", W_READY, 1'b1);
    idle("e1", 0, 0, 0);
    chk("e1.err", SWAP_ERR, 1'b0);
    idle("e2", 0, 0, 0);
    idle("e3", 0, 0, 0);
    idle("e4", 0, 0, 0);
    idle("e5", 1, 6, 6);
    idle("e6", 0, 0, 0);
    beat(3, 5);
    chk("e.full3", W_FULL, 1'b1);

    // Stall of three cycles while an output is valid; W = [2,2],[2,2],[3,5]
    cyc("t0", 1, 1, 1, 1, 1, 1, 0, 0, 0);
    cyc("t1", 1, 1, 0, 1, 0, 0, 0, 0, 0);
    idle("t2", 0, 0, 0);
    idle("t3", 0, 0, 0);
    idle("t4", 0, 0, 0);
    idle("t5", 1, 7, 9);
    cyc("t6", 0, 1, 1, 5, 5, 5, 0, 0, 0);
    chk("t6.err", SWAP_ERR, 1'b0);
    chk("t6.hold0", Result[0], 7);
    chk("t6.hold1", Result[1], 9);
    cyc("t7", 0, 1, 1, 5, 5, 5, 0, 0, 0);
    cyc("t8", 0, 1, 1, 5, 5, 5, 0, 0, 0);
    chk("t8.err", SWAP_ERR, 1'b0);
    idle("t9", 1, 2, 2);
    idle("t10", 0, 0, 0);
    idle("t11", 0, 0, 0);

    // Accumulator wrap: 3 * (-128 * -128) = 49152 -> -16384 in 16 bits
    beat(-128, -128);
    beat(-128, -128);
    beat(-128, -128);
    chk("w.full", W_FULL, 1'b1);
    cyc("w0", 1, 1, 1, -128, -128, -128, 0, 0, 0);
    idle("w1", 0, 0, 0);
    idle("w2", 0, 0, 0);
    idle("w3", 0, 0, 0);
    idle("w4", 0, 0, 0);
    idle("w5", 1, -16384, -16384);
    idle("w6", 0, 0, 0);

    // Asynchronous reset mid-cycle with vectors in flight
    beat(1, 1);
    beat(1, 1);
    beat(1, 1);
    chk("a.full", W_FULL, 1'b1);
    cyc("a0", 1, 1, 1, 1, 1, 1, 0, 0, 0);
    cyc("a1", 1, 1, 0, 1, 1, 1, 0, 0, 0);
    #2;
    ASYNC_RST = 1'b0;
    #1;
    chk("ar.ov", OUT_VALID, 1'b0);
    chk("ar.rdy", W_READY, 1'b1);
    chk("ar.full", W_FULL, 1'b0);
    chk("ar.err", SWAP_ERR, 1'b0);
    chk("ar.res0", Result[0], 0);
    chk("ar.res1", Result[1], 0);
    #1;
    ASYNC_RST = 1'b1;
    for (int i = 0; i < 8; i++) idle("ar.flush", 0, 0, 0);

    // Synchronous reset with a swap wavefront half way through the array
    beat(1, 2);
    beat(1, 2);
    beat(1, 2);
    chk("y.full", W_FULL, 1'b1);
    cyc("y0", 1, 1, 1, 1, 1, 1, 0, 0, 0);
    idle("y1", 0, 0, 0);
    SYNC_RST = 1'b1;
    idle("y2", 0, 0, 0);
    SYNC_RST = 1'b0;
    chk("y2.full", W_FULL, 1'b0);
    chk("y2.rdy", W_READY, 1'b1);
    for (int i = 0; i < 5; i++) idle("y.flush", 0, 0, 0);
    cyc("y8", 1, 1, 0, 1, 1, 1, 0, 0, 0);
    idle("y9", 0, 0, 0);
    idle("y10", 0, 0, 0);
    idle("y11", 0, 0, 0);
    idle("y12", 0, 0, 0);
    idle("y13", 1, 0, 0);
    idle("y14", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_mmu_stream.md
Name: systolic_mmu_stream

Overview:
- Weight-stationary ROWS x COLS systolic matrix-multiply engine.
- Successor to the square unit: generalises it to non-square arrays, and moves input skew and output deskew inside the block.
- Adds a double-buffered weight store with a handshake. A weight swap travels with the data wavefront, so the array never drains between weight sets.
- Sits between the activation feeder and the accumulator buffers. One aligned activation vector in produces one aligned result vector out.

Parameters:
- DATA_WIDTH, 8, signed activation/weight width.
- ACCUMULATOR_DATA_WIDTH, 32, signed partial-sum/result width (>= 2*DATA_WIDTH).
- ROWS, 4, array rows; activation vector length.
- COLS, 4, array columns; result vector length.

Ports:
- CLK  in  1  clock, rising edge.
- ASYNC_RST  in  1  reset, asynchronous, active-low.
- SYNC_RST  in  1  synchronous reset, active-high; same clearing effect as ASYNC_RST.
- EN  in  1  pipeline advance enable.
- IN_VALID  in  1  Inputs holds a valid activation vector.
- SWAP  in  1  sampled only with IN_VALID; this vector and later ones use the shadow weights.
- Inputs  in  [ROWS] x DATA_WIDTH  aligned activation vector (unpacked array).
- W_VALID  in  1  W_Data beat valid.
- W_READY  out  1  shadow store accepts a beat.
- W_Data  in  [COLS] x DATA_WIDTH  one weight row per beat.
- W_FULL  out  1  shadow holds a complete matrix.
- SWAP_ERR  out  1  one-cycle pulse: SWAP requested while W_FULL=0.
- OUT_VALID  out  1  Result valid.
- Result  out  [COLS] x ACCUMULATOR_DATA_WIDTH  aligned result vector.

Behaviour:
- Reset (either reset):
  - All outputs 0, except W_READY=1.
  - Active and shadow weights 0; beat counter 0.
  - All skew, PE, deskew, valid and swap-flag registers cleared.
  - Reset mid-operation discards in-flight vectors; no OUT_VALID is generated for them.
- Math: Result[c] = sum over r of Inputs[r]*W[r][c].
  - Products are full 2*DATA_WIDTH signed, sign-extended.
  - Sums wrap modulo 2^ACCUMULATOR_DATA_WIDTH (two's complement); no saturation.
- Latency: a vector accepted at an EN=1 edge with IN_VALID=1 appears with OUT_VALID=1 after exactly ROWS+COLS further EN=1 edges.
  - Internally: row r skewed r stages, column c deskewed COLS-1-c stages, output registered.
  - Full throughput: one vector per EN=1 cycle.
  - Output order equals input order; bubbles are preserved.
- EN=0:
  - The data pipeline (skew, PEs, deskew, valid, swap flags) and the swap-busy counter hold.
  - IN_VALID, SWAP and SWAP_ERR are ignored/low.
  - OUT_VALID clears at the next edge and Result holds, so no vector is ever reported twice.
  - The weight-load path is independent of EN.
- Weight load:
  - A beat is accepted when W_VALID & W_READY. Beat i (0..ROWS-1) fills shadow row i.
  - After beat ROWS-1: W_FULL=1 and W_READY=0.
  - Beats while W_READY=0 are dropped.
- Swap, when IN_VALID & SWAP & EN with W_FULL=1:
  - A swap flag rides with that vector's activation in every row.
  - PE(r,c) copies its shadow weight to its active weight in the same cycle the flagged activation reaches it. Earlier vectors use the old weights; this vector and later ones use the new weights.
  - W_FULL clears and the beat counter resets.
  - W_READY stays 0 for ROWS+COLS-1 further EN=1 edges, until PE(ROWS-1,COLS-1) has swapped, then returns to 1.
- Swap with W_FULL=0:
  - SWAP_ERR=1 for one cycle.
  - The vector is processed with the current active weights; shadow state is unchanged.
- Back-to-back SWAP:
  - Cannot occur, because W_FULL is 0 during the busy window.
  - A SWAP inside the window is a SWAP_ERR case.
- Weight load and compute may overlap freely outside the busy window.

Test Plan:
- Reset: assert ASYNC_RST=0 mid-cycle -> all outputs 0 and W_READY=1 immediately; no OUT_VALID afterwards from in-flight data.
- Basic multiply (ROWS=3, COLS=2):
  - Load W rows [1,2],[3,4],[5,6] -> W_FULL=1.
  - Send [1,1,1] with SWAP -> OUT_VALID after 5 EN edges, Result=[9,12].
  - Next cycle send [1,-1,2] -> Result=[8,10].
- Streaming with a bubble: vectors v0,v1,-,v2,v3 with W loaded as above -> results appear in order with the identical one-cycle bubble; no drops.
- Swap mid-stream:
  - Active W as above; load W2=all 1s; send v0=[1,1,1] (no swap) then v1=[1,1,1] with SWAP.
  - Expect Result [9,12] then [3,3].
  - W_READY=0 for exactly 4 EN edges after the swap.
- Errors and stall:
  - SWAP with only 2 of 3 beats loaded -> SWAP_ERR pulse; result uses old weights.
  - EN=0 for 3 cycles mid-stream -> latency extends by 3; each vector reported once.
- Wrap (ACCUMULATOR_DATA_WIDTH=16): all inputs and weights -128, ROWS=3 -> 49152 wraps to Result=-16384.
